// File: rtl/line_code_pkg.sv
// Shared types and the half-bit symbol rule for the serial line encoder.
// The symbol rule is pure combinational logic; it depends on the bit and the level at the start of the bit.
package line_code_pkg;

  typedef enum logic [1:0] {
    LC_THOMAS = 2'b00,
    LC_IEEE   = 2'b01,
    LC_DIFF   = 2'b10,
    LC_NRZI   = 2'b11
  } line_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FIRST  = 2'b01,
    SECOND = 2'b10
  } fsm_state_t;

  // level is the line level at the end of the previous bit
  function automatic logic half_symbol(input line_mode_t mode, input logic b,
                                       input logic level, input logic second);
    logic r;
    r = 1'b0;
    case (mode)
      LC_THOMAS: r = second ? ~b : b;
      LC_IEEE:   r = second ? b : ~b;
      LC_DIFF:   r = second ? (level ^ b) : (level ^ ~b);
      LC_NRZI:   r = level ^ b;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/line_code_encoder_if.sv
// Word-in / line-out bundle of the line encoder: word handshake from the source, line signals to the driver.
// slave is the encoder side, master is the transmit source / line-driver side.
interface line_code_encoder_if #(parameter int DATA_W = 8);
  logic [1:0]        mode;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              line_out;
  logic              line_en;
  logic              done;

  modport master (
    output mode, s_data, s_valid,
    input  s_ready, line_out, line_en, done
  );

  modport slave (
    input  mode, s_data, s_valid,
    output s_ready, line_out, line_en, done
  );
endinterface

// File: rtl/half_bit_timer.sv
// Counts HALF_DIV cycles while run is high; tick marks the final cycle of each half-bit.
// Held at zero while idle so the first half after an accept always gets its full length.
module half_bit_timer #(
  parameter int HALF_DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic tick
);
  localparam int CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = run && (cnt == CNT_W'(HALF_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset || !run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/line_code_encoder.sv
// Serialises accepted words into two half-bit symbols per bit; first half on line_out the cycle after accept.
// s_ready is high only in IDLE or the final cycle of a word, so back-to-back words run without a gap.
module line_code_encoder
  import line_code_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int HALF_DIV  = 1,
  parameter int MSB_FIRST = 1
) (
  input logic               clock,
  input logic               reset,
  line_code_encoder_if.slave bus
);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  fsm_state_t        state, state_nx;
  logic [DATA_W-1:0] shreg, shreg_nx, shifted;
  logic [IDX_W-1:0]  bit_idx, bit_idx_nx;
  line_mode_t        mode_q, mode_nx, in_mode;
  logic              level, level_nx;
  logic              line_q, line_nx;
  logic              tick, last_bit, end_word, ready, accept;

  function automatic logic lead_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  half_bit_timer #(.HALF_DIV(HALF_DIV)) u_timer (
    .clock (clock),
    .reset (reset),
    .run   (state != IDLE),
    .tick  (tick)
  );

  assign in_mode  = line_mode_t'(bus.mode);
  assign shifted  = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
  assign last_bit = (bit_idx == IDX_W'(DATA_W - 1));
  assign end_word = (state == SECOND) && tick && last_bit;
  assign ready    = !reset && ((state == IDLE) || end_word);
  assign accept   = bus.s_valid && ready;

  assign bus.s_ready  = ready;
  assign bus.done     = end_word && !reset;
  assign bus.line_out = line_q;
  assign bus.line_en  = (state != IDLE);

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_idx_nx = bit_idx;
    mode_nx    = mode_q;
    level_nx   = level;
    line_nx    = line_q;
    case (state)
      IDLE: ;
      FIRST: begin
        if (tick) begin
          state_nx = SECOND;
          line_nx  = half_symbol(mode_q, lead_bit(shreg), level, 1'b1);
        end
      end
      SECOND: begin
        if (tick && !last_bit) begin
          state_nx   = FIRST;
          shreg_nx   = shifted;
          bit_idx_nx = bit_idx + 1'b1;
          level_nx   = line_q;
          line_nx    = half_symbol(mode_q, lead_bit(shifted), line_q, 1'b0);
        end else if (tick) begin
          state_nx   = IDLE;
          bit_idx_nx = '0;
          // Manchester codes return to zero; level-based codes hold the line
          line_nx    = ((mode_q == LC_DIFF) || (mode_q == LC_NRZI)) ? line_q : 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (accept) begin
      state_nx   = FIRST;
      shreg_nx   = bus.s_data;
      bit_idx_nx = '0;
      mode_nx    = in_mode;
      level_nx   = line_q;
      line_nx    = half_symbol(in_mode, lead_bit(bus.s_data), line_q, 1'b0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      mode_q  <= LC_THOMAS;
      level   <= 1'b0;
      line_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bit_idx <= bit_idx_nx;
      mode_q  <= mode_nx;
      level   <= level_nx;
      line_q  <= line_nx;
    end
  end
endmodule

// File: tb/tb_line_code_encoder.sv
// Directed bench for line_code_encoder: one DUT at HALF_DIV=2/MSB-first, one at HALF_DIV=1/LSB-first.
module tb_line_code_encoder;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  line_code_encoder_if #(.DATA_W(8)) bus0 ();
  line_code_encoder_if #(.DATA_W(8)) bus1 ();

  line_code_encoder #(.DATA_W(8), .HALF_DIV(2), .MSB_FIRST(1)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  line_code_encoder #(.DATA_W(8), .HALF_DIV(1), .MSB_FIRST(0)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus0.s_valid = 1'b0; bus0.mode = 2'b00; bus0.s_data = 8'h00;
    bus1.s_valid = 1'b0; bus1.mode = 2'b00; bus1.s_data = 8'h00;
    repeat (3) step();
    checks++; if (bus0.line_out !== 1'b0) begin errors++; $display("FAIL reset_line_out: got %b want 0", bus0.line_out); end
    checks++; if (bus0.line_en !== 1'b0) begin errors++; $display("FAIL reset_line_en: got %b want 0", bus0.line_en); end
    checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus0.done); end
    checks++; if (bus0.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready_in_reset: got %b want 0", bus0.s_ready); end
    checks++; if (bus1.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready1_in_reset: got %b want 0", bus1.s_ready); end
    reset = 1'b0;
    #1;
    checks++; if (bus0.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready_after: got %b want 1", bus0.s_ready); end
    checks++; if (bus1.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready1_after: got %b want 1", bus1.s_ready); end
    step();
    checks++; if (bus0.line_out !== 1'b0) begin errors++; $display("FAIL reset_idle_line_out: got %b want 0", bus0.line_out); end
  endtask

  task automatic test_thomas();
    logic [15:0] exp;
    exp = 16'b10_01_10_01_01_10_01_10;
    bus0.mode = 2'b00; bus0.s_data = 8'hA5; bus0.s_valid = 1'b1;
    checks++; if (bus0.s_ready !== 1'b1) begin errors++; $display("FAIL thomas_ready: got %b want 1", bus0.s_ready); end
    step();
    bus0.s_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++; if (bus0.line_out !== exp[15 - i/2]) begin errors++; $display("FAIL thomas_line cyc %0d: got %b want %b", i, bus0.line_out, exp[15 - i/2]); end
      checks++; if (bus0.line_en !== 1'b1) begin errors++; $display("FAIL thomas_en cyc %0d: got %b want 1", i, bus0.line_en); end
      checks++; if (bus0.done !== (i == 31)) begin errors++; $display("FAIL thomas_done cyc %0d: got %b want %b", i, bus0.done, (i == 31)); end
      checks++; if (bus0.s_ready !== (i == 31)) begin errors++; $display("FAIL thomas_s_ready cyc %0d: got %b want %b", i, bus0.s_ready, (i == 31)); end
      step();
    end
    checks++; if (bus0.line_out !== 1'b0) begin errors++; $display("FAIL thomas_idle_line: got %b want 0", bus0.line_out); end
    checks++; if (bus0.line_en !== 1'b0) begin errors++; $display("FAIL thomas_idle_en: got %b want 0", bus0.line_en); end
    checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL thomas_idle_done: got %b want 0", bus0.done); end
  endtask

  task automatic test_ieee();
    logic [15:0] exp;
    exp = 16'b01_10_01_10_10_01_10_01;
    bus0.mode = 2'b01; bus0.s_data = 8'hA5; bus0.s_valid = 1'b1;
    step();
    bus0.s_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++; if (bus0.line_out !== exp[15 - i/2]) begin errors++; $display("FAIL ieee_line cyc %0d: got %b want %b", i, bus0.line_out, exp[15 - i/2]); end
      checks++; if (bus0.done !== (i == 31)) begin errors++; $display("FAIL ieee_done cyc %0d: got %b want %b", i, bus0.done, (i == 31)); end
      step();
    end
    checks++; if (bus0.line_out !== 1'b0) begin errors++; $display("FAIL ieee_idle_line: got %b want 0", bus0.line_out); end
    checks++; if (bus0.line_en !== 1'b0) begin errors++; $display("FAIL ieee_idle_en: got %b want 0", bus0.line_en); end
  endtask

  task automatic test_diff();
    logic [15:0] exp;
    exp = 16'b10_10_10_10_01_10_01_10;
    bus0.mode = 2'b10; bus0.s_data = 8'h0F; bus0.s_valid = 1'b1;
    step();
    bus0.s_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++; if (bus0.line_out !== exp[15 - i/2]) begin errors++; $display("FAIL diff_line cyc %0d: got %b want %b", i, bus0.line_out, exp[15 - i/2]); end
      checks++; if (bus0.line_en !== 1'b1) begin errors++; $display("FAIL diff_en cyc %0d: got %b want 1", i, bus0.line_en); end
      step();
    end
    step(); step();
    checks++; if (bus0.line_out !== 1'b0) begin errors++; $display("FAIL diff_idle_line: got %b want 0", bus0.line_out); end
    checks++; if (bus0.line_en !== 1'b0) begin errors++; $display("FAIL diff_idle_en: got %b want 0", bus0.line_en); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] lev;
    lev = 8'b1000_1100;
    bus0.mode = 2'b11; bus0.s_data = 8'hCA; bus0.s_valid = 1'b1;
    step();
    bus0.s_data = 8'h80; bus0.s_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      checks++; if (bus0.line_out !== lev[7 - i/4]) begin errors++; $display("FAIL nrzi_line cyc %0d: got %b want %b", i, bus0.line_out, lev[7 - i/4]); end
      checks++; if (bus0.s_ready !== (i == 31)) begin errors++; $display("FAIL nrzi_s_ready cyc %0d: got %b want %b", i, bus0.s_ready, (i == 31)); end
      checks++; if (bus0.done !== (i == 31)) begin errors++; $display("FAIL nrzi_done cyc %0d: got %b want %b", i, bus0.done, (i == 31)); end
      step();
    end
    bus0.s_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++; if (bus0.line_out !== 1'b1) begin errors++; $display("FAIL b2b_line cyc %0d: got %b want 1", i, bus0.line_out); end
      checks++; if (bus0.line_en !== 1'b1) begin errors++; $display("FAIL b2b_en cyc %0d: got %b want 1", i, bus0.line_en); end
      checks++; if (bus0.done !== (i == 31)) begin errors++; $display("FAIL b2b_done cyc %0d: got %b want %b", i, bus0.done, (i == 31)); end
      step();
    end
    checks++; if (bus0.line_out !== 1'b1) begin errors++; $display("FAIL b2b_idle_hold: got %b want 1", bus0.line_out); end
    checks++; if (bus0.line_en !== 1'b0) begin errors++; $display("FAIL b2b_idle_en: got %b want 0", bus0.line_en); end
  endtask

  task automatic test_half_div1();
    logic [15:0] exp;
    exp = 16'b10_01_01_01_01_01_01_01;
    bus1.mode = 2'b00; bus1.s_data = 8'h01; bus1.s_valid = 1'b1;
    step();
    bus1.s_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus1.line_out !== exp[15 - i]) begin errors++; $display("FAIL hd1_line cyc %0d: got %b want %b", i, bus1.line_out, exp[15 - i]); end
      checks++; if (bus1.line_en !== 1'b1) begin errors++; $display("FAIL hd1_en cyc %0d: got %b want 1", i, bus1.line_en); end
      checks++; if (bus1.s_ready !== (i == 15)) begin errors++; $display("FAIL hd1_s_ready cyc %0d: got %b want %b", i, bus1.s_ready, (i == 15)); end
      checks++; if (bus1.done !== (i == 15)) begin errors++; $display("FAIL hd1_done cyc %0d: got %b want %b", i, bus1.done, (i == 15)); end
      step();
    end
    checks++; if (bus1.line_out !== 1'b0) begin errors++; $display("FAIL hd1_idle_line: got %b want 0", bus1.line_out); end
    checks++; if (bus1.line_en !== 1'b0) begin errors++; $display("FAIL hd1_idle_en: got %b want 0", bus1.line_en); end
  endtask

  task automatic test_reset_midword();
    bus0.mode = 2'b00; bus0.s_data = 8'hFF; bus0.s_valid = 1'b1;
    step();
    bus0.s_valid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      checks++; if (bus0.line_out !== (((c - 1) / 2) % 2 == 0)) begin errors++; $display("FAIL midrst_line cyc %0d: got %b want %b", c, bus0.line_out, (((c - 1) / 2) % 2 == 0)); end
      step();
    end
    reset = 1'b1;
    #1;
    checks++; if (bus0.s_ready !== 1'b0) begin errors++; $display("FAIL midrst_s_ready_in_reset: got %b want 0", bus0.s_ready); end
    step();
    checks++; if (bus0.line_out !== 1'b0) begin errors++; $display("FAIL midrst_line_after: got %b want 0", bus0.line_out); end
    checks++; if (bus0.line_en !== 1'b0) begin errors++; $display("FAIL midrst_en_after: got %b want 0", bus0.line_en); end
    checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL midrst_done_after: got %b want 0", bus0.done); end
    reset = 1'b0;
    #1;
    checks++; if (bus0.s_ready !== 1'b1) begin errors++; $display("FAIL midrst_s_ready_release: got %b want 1", bus0.s_ready); end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL midrst_residual_done cyc %0d: got %b want 0", c, bus0.done); end
    end
    bus0.mode = 2'b00; bus0.s_data = 8'h00; bus0.s_valid = 1'b1;
    step();
    bus0.s_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++; if (bus0.line_out !== ((i / 2) % 2 == 1)) begin errors++; $display("FAIL midrst_new_line cyc %0d: got %b want %b", i, bus0.line_out, ((i / 2) % 2 == 1)); end
      checks++; if (bus0.done !== (i == 31)) begin errors++; $display("FAIL midrst_new_done cyc %0d: got %b want %b", i, bus0.done, (i == 31)); end
      step();
    end
    checks++; if (bus0.line_en !== 1'b0) begin errors++; $display("FAIL midrst_new_idle_en: got %b want 0", bus0.line_en); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_thomas();
    test_ieee();
    test_diff();
    test_back_to_back();
    test_half_div1();
    test_reset_midword();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
